// File: rtl/mem_access_unit.sv
// mem_access_unit: MAR-driven single read/write cycle on a req/ack memory port,
// holding data in the MDR with ARMv4 byte-lane selection and unaligned-word rotation.
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MIO_EN,
  input  logic        R_W,
  input  logic        DATA_SIZE,
  input  logic [31:0] address,
  input  logic        LD_MDR,
  input  logic [31:0] ALU_bus,
  output logic [31:0] mdr,
  output logic        R,
  output logic        ERR,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] mdr_q, mdr_d, addr_q, addr_d, wdata_q, wdata_d;
  logic [31:0] ld_val, rot, rd_fmt;
  logic [1:0]  a_q, a_d;
  logic        rw_q, rw_d, size_q, size_d, err_q, err_d;
  logic        start, ack, tmo;
  always_comb begin
    start   = (state_q == IDLE) && MIO_EN;
    ack     = (state_q == REQ) && mem_ack;
    tmo     = (state_q == REQ) && !mem_ack && (cnt_q == CW'(TIMEOUT - 1));
    ld_val  = LD_MDR ? ALU_bus : mdr_q;
    // Rotating right by 8*a also puts byte lane a at bits 7:0 for byte loads.
    rot     = (a_q == 2'd1) ? {mem_rdata[7:0], mem_rdata[31:8]} :
              (a_q == 2'd2) ? {mem_rdata[15:0], mem_rdata[31:16]} :
              (a_q == 2'd3) ? {mem_rdata[23:0], mem_rdata[31:24]} : mem_rdata;
    rd_fmt  = size_q ? {24'h0, rot[7:0]} : rot;
    state_d = start ? REQ : (ack || tmo) ? DONE : (state_q == DONE) ? IDLE : state_q;
    cnt_d   = (state_q == REQ) ? cnt_q + 1'b1 : '0;
    mdr_d   = (state_q == IDLE) ? ld_val : (ack && !rw_q) ? rd_fmt : mdr_q;
    addr_d  = start ? {address[31:2], 2'b00} : addr_q;
    a_d     = start ? address[1:0] : a_q;
    rw_d    = start ? R_W : rw_q;
    size_d  = start ? DATA_SIZE : size_q;
    wdata_d = start ? (DATA_SIZE ? {4{ld_val[7:0]}} : ld_val) : wdata_q;
    err_d   = tmo ? 1'b1 : ack ? 1'b0 : err_q;
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mdr_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      a_q     <= '0;
      rw_q    <= 1'b0;
      size_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mdr_q   <= mdr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      a_q     <= a_d;
      rw_q    <= rw_d;
      size_q  <= size_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    mem_req   = (state_q == REQ);
    mem_we    = mem_req && rw_q;
    mem_be    = !mem_req ? 4'h0 : (rw_q && size_q) ? 4'b0001 << a_q : 4'hF;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mdr       = mdr_q;
    R         = (state_q == DONE);
    ERR       = R && err_q;
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed bench with a scoreboard of expected MDR values
// popped whenever the unit reports completion.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        RESET = 1'b1;
  logic        MIO_EN = 1'b0, R_W = 1'b0, DATA_SIZE = 1'b0, LD_MDR = 1'b0, mem_ack = 1'b0;
  logic [31:0] address = '0, ALU_bus = '0, mem_rdata = '0;
  logic [31:0] mdr, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        R, ERR, mem_req, mem_we;
  int          checks = 0, errors = 0;
  logic [31:0] sb[$];

  mem_access_unit #(.TIMEOUT(4)) dut (
    .CLK(clk), .RESET(RESET), .MIO_EN(MIO_EN), .R_W(R_W), .DATA_SIZE(DATA_SIZE),
    .address(address), .LD_MDR(LD_MDR), .ALU_bus(ALU_bus), .mdr(mdr), .R(R), .ERR(ERR),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [31:0] a, input logic rw, input logic sz,
                        input logic ld, input logic [31:0] bus);
    @(negedge clk);
    address = a; R_W = rw; DATA_SIZE = sz; LD_MDR = ld; ALU_bus = bus; MIO_EN = 1'b1;
    @(posedge clk);
    #1 MIO_EN = 1'b0; LD_MDR = 1'b0;
  endtask

  task automatic ack_after(input int waits, input logic [31:0] rd);
    repeat (waits) @(posedge clk);
    @(negedge clk);
    mem_rdata = rd; mem_ack = 1'b1;
    @(posedge clk);
    #1 mem_ack = 1'b0;
  endtask

  task automatic wait_r(input string tag, input logic exp_err, input int exp_lat);
    int n = 0;
    @(negedge clk);
    while (!R && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_r"}, {31'h0, R}, 32'h1);
    chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_err"}, {31'h0, ERR}, {31'h0, exp_err});
    if (sb.size() == 0) chk({tag, "_sb_empty"}, 32'h1, 32'h0);
    else chk({tag, "_mdr"}, mdr, sb.pop_front());
    @(negedge clk);
    chk({tag, "_r_pulse"}, {31'h0, R}, 32'h0);
  endtask

  initial begin
    int reqc;
    int n;
    #12;
    chk("rst_mdr", mdr, 32'h0);
    chk("rst_r", {31'h0, R}, 32'h0);
    chk("rst_req", {31'h0, mem_req}, 32'h0);
    chk("rst_be", {28'h0, mem_be}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    @(negedge clk) RESET = 1'b0;

    // ack while idle must be ignored
    @(negedge clk) mem_ack = 1'b1;
    @(posedge clk) #1 mem_ack = 1'b0;
    @(negedge clk);
    chk("idle_ack_r", {31'h0, R}, 32'h0);
    chk("idle_ack_req", {31'h0, mem_req}, 32'h0);

    // aligned word read, ack in second REQ cycle
    sb.push_back(32'hAABBCCDD);
    launch(32'h0000_1000, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("wr_req", {31'h0, mem_req}, 32'h1);
    chk("wr_addr", mem_addr, 32'h0000_1000);
    chk("wr_be", {28'h0, mem_be}, 32'hF);
    chk("wr_we", {31'h0, mem_we}, 32'h0);
    chk("wr_r_early", {31'h0, R}, 32'h0);
    ack_after(1, 32'hAABBCCDD);
    wait_r("wread", 1'b0, 0);

    // unaligned word read rotates right by 16
    sb.push_back(32'hCCDDAABB);
    launch(32'h0000_1002, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("ur_addr", mem_addr, 32'h0000_1000);
    chk("ur_be", {28'h0, mem_be}, 32'hF);
    ack_after(0, 32'hAABBCCDD);
    wait_r("uread", 1'b0, 0);

    // byte read from lane 3
    sb.push_back(32'h0000_0011);
    launch(32'h0000_2003, 1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk("br_addr", mem_addr, 32'h0000_2000);
    chk("br_be", {28'h0, mem_be}, 32'hF);
    ack_after(0, 32'h11223344);
    wait_r("bread", 1'b0, 0);

    // byte write with MDR loaded on the launching edge
    sb.push_back(32'h0000_00A5);
    launch(32'h0000_3001, 1'b1, 1'b1, 1'b1, 32'h0000_00A5);
    @(negedge clk);
    chk("bw_we", {31'h0, mem_we}, 32'h1);
    chk("bw_be", {28'h0, mem_be}, 32'h2);
    chk("bw_wdata", mem_wdata, 32'hA5A5A5A5);
    chk("bw_addr", mem_addr, 32'h0000_3000);
    ack_after(0, 32'hDEADBEEF);
    wait_r("bwrite", 1'b0, 0);
    chk("bw_be_idle", {28'h0, mem_be}, 32'h0);
    chk("bw_wdata_hold", mem_wdata, 32'hA5A5A5A5);

    // timeout: no ack, mdr untouched
    sb.push_back(32'h0000_00A5);
    mem_rdata = 32'h12345678;
    launch(32'h0000_4000, 1'b0, 1'b0, 1'b0, 32'h0);
    reqc = 0;
    n = 0;
    @(negedge clk);
    while (!R && n < 40) begin
      if (mem_req) reqc++;
      @(negedge clk);
      n++;
    end
    chk("to_req_cycles", reqc, 4);
    chk("to_r", {31'h0, R}, 32'h1);
    chk("to_err", {31'h0, ERR}, 32'h1);
    chk("to_mdr", mdr, sb.pop_front());
    @(negedge clk);
    chk("to_r_pulse", {31'h0, R}, 32'h0);
    chk("to_idle_req", {31'h0, mem_req}, 32'h0);

    // reset in second REQ cycle, ack arriving right after
    launch(32'h0000_5000, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("rm_req_before", {31'h0, mem_req}, 32'h1);
    @(posedge clk);
    #2 RESET = 1'b1;
    #1 chk("rm_req_async", {31'h0, mem_req}, 32'h0);
    mem_rdata = 32'h99887766; mem_ack = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rm_no_r", {31'h0, R}, 32'h0);
    end
    chk("rm_mdr", mdr, 32'h0);
    @(negedge clk) RESET = 1'b0; mem_ack = 1'b0;

    // fresh unaligned read after reset, ack in first REQ cycle
    sb.push_back(32'h44112233);
    launch(32'h0000_6001, 1'b0, 1'b0, 1'b0, 32'h0);
    ack_after(0, 32'h11223344);
    wait_r("fresh", 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
